ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage feeding the single-cycle `cpu` core. It owns the fetch program counter and issues in-order word requests to instruction memory over a valid/ready request channel. It buffers returned instructions in a small prefetch FIFO and presents them, tagged with their PC, to the core through a valid/ready handshake. A taken branch or jump from the core arrives as a redirect; the stage flushes the FIFO and discards any responses still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; asynchronous, active-high
- `i_redirect`  in  1  core requests a fetch redirect this cycle
- `i_redirect_pc`  in  32  redirect target
- `o_req_valid`  out  1  instruction memory request valid
- `i_req_ready`  in  1  memory accepts the request
- `o_req_addr`  out  32  word address of the request (byte address, bits [1:0] = 0)
- `i_rsp_valid`  in  1  response valid; responses return in request order, no backpressure
- `i_rsp_data`  in  32  instruction word
- `o_inst_valid`  out  1  head FIFO entry valid
- `i_inst_ready`  in  1  core consumes the head entry
- `o_inst`  out  32  instruction
- `o_inst_pc`  out  32  PC of `o_inst`
- `o_fault`  out  1  misaligned redirect fault; present only with `IFETCH_ALIGN_CHECK_EN`

## Operation
- `fetch_pc` holds the next request address. It advances by 4 on each request handshake (`o_req_valid && i_req_ready`) and wraps modulo 2^32.
- `outstanding` counts accepted requests whose responses have not yet returned.
- Credit rule: `o_req_valid = !i_rst_q && (outstanding + fifo_count < DEPTH)`. Each accepted request is therefore guaranteed a FIFO slot.
- The `pc_q` FIFO, parallel to the data FIFO, stores the request address of each response. It is written in order from a small address queue of `DEPTH` entries.
- On response with `drop_cnt == 0`: push `{i_rsp_data, pc}` into the FIFO. On response with `drop_cnt > 0`: discard it and decrement `drop_cnt`.
- Pop when `o_inst_valid && i_inst_ready`. Simultaneous push and pop at full or empty is legal, and the count stays unchanged.
- Redirect has priority over all other events in its cycle:
  - `fetch_pc <= i_redirect_pc`
  - the FIFO and address queue are flushed
  - `drop_cnt <= outstanding + (req handshake this cycle) − (rsp_valid this cycle)`
  - a response arriving in the redirect cycle is discarded
  - `o_inst_valid` is 0 in the cycle after the redirect
- A request handshake in the redirect cycle uses the old `fetch_pc` and is counted as stale.
- No new request is issued while `drop_cnt != 0`. This keeps response ordering unambiguous.
- All outputs are driven from registers except `o_req_valid`, which is combinational from counters only (no input dependence).

## Timing
- Reset values: `fetch_pc = RESET_PC`, `outstanding = 0`, `drop_cnt = 0`, FIFO empty. Outputs during reset: `o_req_valid = 0`, `o_inst_valid = 0`, `o_inst = 0`, `o_inst_pc = 0`, `o_fault = 0`.
- `i_rst_q` is `i_rst` registered once. The first `o_req_valid` is asserted one cycle after `i_rst` deasserts.
- A response returned in cycle N is visible at `o_inst_valid` in cycle N+1. There is no bypass.
- Minimum request-to-instruction latency is 2 cycles with 1-cycle memory.
- Sustained throughput is one instruction per cycle when memory latency ≤ `DEPTH`−1.
- Reset asserted mid-operation clears everything asynchronously. Responses to requests accepted before reset are the memory's responsibility to squash; the same reset goes to instruction memory.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - a redirect with `i_redirect_pc[1:0] != 0` sets `o_fault` (sticky until reset)
  - the redirect is otherwise ignored, with no flush and no PC change
  - while `o_fault` is set, `o_req_valid = 0`
- Not defined: `o_fault` port absent; `i_redirect_pc[1:0]` is forced to 0 on load.

## Structure
- A shared `ifetch_pkg` holds:
  - `typedef struct packed { logic [31:0] inst; logic [31:0] pc; } fetch_entry_t`
  - `localparam INST_NOP = 32'h00000013`
- One sub-module, `ifetch_fifo`: a synchronous FIFO parameterised on `DEPTH` and entry type. It provides push/pop/flush and a count output, and holds its storage in an array `q` so the bench can peek at entries.

## Test plan
- Reset with `RESET_PC = 32'h100`, memory returning `addr ^ 32'hA5A5A5A5` with 1-cycle latency, `i_inst_ready = 1` → requests to 0x100, 0x104, 0x108 on consecutive cycles; first `o_inst_valid` 2 cycles after the first request, with `o_inst_pc = 0x100` and `o_inst = 0xA5A5A4A5`.
- `i_inst_ready = 0` held → exactly 4 requests accepted, then `o_req_valid = 0`. After releasing ready, 0x100–0x10C are popped in order and fetching resumes at 0x110.
- Memory latency 3 cycles with 2 requests outstanding, redirect to 0x200 → both stale responses are discarded; the next `o_inst_pc` is 0x200; no request is issued until `drop_cnt = 0`.
- Redirect in the same cycle as a request handshake and a response → the old-PC request is dropped, the response is discarded, and the first new instruction has `o_inst_pc = 0x200`.
- `fetch_pc = 32'hFFFFFFFC` → the next request address is 0x00000000.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 0x202 → `o_fault = 1` next cycle, `o_req_valid = 0`, FIFO contents unchanged. Without the macro, the same redirect fetches from 0x200.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
module ifetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       wdata,
    output T                       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                q[wr_ptr] <= wdata;
                wr_ptr    <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: credit-based prefetch with redirect flush.
// Optional misaligned-redirect fault: define IFETCH_ALIGN_CHECK_EN.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic        o_fault
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rst_q;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] aq_count;
    logic [CW:0]   credit_used;
    logic          req_hs;
    logic          rsp_keep;
    logic          inst_pop;
    logic          redirect_take;
    logic          stall;
    logic [31:0]   target;
    logic [31:0]   aq_head;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault;
    logic bad_align;

    assign bad_align     = i_redirect && (i_redirect_pc[1:0] != 2'b00);
    assign redirect_take = i_redirect && !bad_align;
    assign target        = i_redirect_pc;
    assign stall         = fault;
    assign o_fault       = fault;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fault <= 1'b0;
        end else if (bad_align) begin
            fault <= 1'b1;
        end
    end
`else
    assign redirect_take = i_redirect;
    assign target        = word_align(i_redirect_pc);
    assign stall         = 1'b0;
`endif

    // Outstanding requests always own a FIFO slot, so responses never stall.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign o_req_valid = !rst_q && !stall && (drop_cnt == '0)
                         && (credit_used < (CW+1)'(DEPTH));
    assign o_req_addr  = fetch_pc;
    assign req_hs      = o_req_valid && i_req_ready;

    assign rsp_keep = i_rsp_valid && !redirect_take
                      && (drop_cnt == '0) && (aq_count != '0);
    assign inst_pop = o_inst_valid && i_inst_ready;

    assign wentry.inst = i_rsp_data;
    assign wentry.pc   = aq_head;

    assign o_inst_valid = (fifo_count != '0);
    assign o_inst       = head.inst;
    assign o_inst_pc    = head.pc;

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [31:0])
    ) u_addr_q (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (req_hs && !redirect_take),
        .pop   (rsp_keep),
        .flush (redirect_take),
        .wdata (fetch_pc),
        .rdata (aq_head),
        .count (aq_count)
    );

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_data_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (rsp_keep),
        .pop   (inst_pop),
        .flush (redirect_take),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_q       <= 1'b1;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            rst_q       <= 1'b0;
            outstanding <= outstanding + CW'(req_hs) - CW'(i_rsp_valid);
            // Everything still in flight at a redirect belongs to the old stream.
            if (redirect_take) begin
                fetch_pc <= target;
                drop_cnt <= outstanding + CW'(req_hs) - CW'(i_rsp_valid);
            end else begin
                if (req_hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (i_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a fixed-latency instruction memory model.
module tb_ifetch;
    import ifetch_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_req_valid;
    logic        i_req_ready = 1'b0;
    logic [31:0] o_req_addr;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_data = '0;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        o_fault;
`endif

    always #5 i_clk = ~i_clk;

    ifetch #(
        .RESET_PC (32'h100),
        .DEPTH    (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_req_valid   (o_req_valid),
        .i_req_ready   (i_req_ready),
        .o_req_addr    (o_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .o_inst_valid  (o_inst_valid),
        .i_inst_ready  (i_inst_ready),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .o_fault       (o_fault)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    ev_t   req_log[$];
    ev_t   pop_log[$];
    pend_t pend[$];
    int    cyc = 0;
    int    lat = 1;

    // Memory returns addr ^ A5A5A5A5 exactly lat cycles after acceptance.
    always @(posedge i_clk) begin
        logic        hs;
        logic        pp;
        logic [31:0] a;
        logic [31:0] ppc;
        logic [31:0] pin;
        hs  = o_req_valid && i_req_ready;
        a   = o_req_addr;
        pp  = o_inst_valid && i_inst_ready;
        ppc = o_inst_pc;
        pin = o_inst;
        cyc++;
        if (!i_rst) begin
            if (hs) begin
                req_log.push_back('{a, 32'h0, cyc - 1});
                pend.push_back('{a, cyc - 1 + lat});
            end
            if (pp) begin
                pop_log.push_back('{ppc, pin, cyc - 1});
            end
        end
        #1;
        if (i_rst) begin
            pend.delete();
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = pend[0].addr ^ 32'hA5A5A5A5;
            void'(pend.pop_front());
        end else begin
            i_rsp_valid = 1'b0;
            i_rsp_data  = '0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    function automatic ev_t req_at(input int i);
        ev_t e;
        e = '{32'hDEADBEEF, 32'hDEADBEEF, -1};
        if (i >= 0 && i < req_log.size()) e = req_log[i];
        return e;
    endfunction

    function automatic ev_t pop_at(input int i);
        ev_t e;
        e = '{32'hDEADBEEF, 32'hDEADBEEF, -1};
        if (i >= 0 && i < pop_log.size()) e = pop_log[i];
        return e;
    endfunction

    function automatic int first_req_after(input int c);
        for (int i = 0; i < req_log.size(); i++) begin
            if (req_log[i].cyc > c) return i;
        end
        return -1;
    endfunction

    function automatic int first_pop_after(input int c);
        for (int i = 0; i < pop_log.size(); i++) begin
            if (pop_log[i].cyc > c) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        i_rst      = 1'b1;
        i_redirect = 1'b0;
        step(2);
        req_log.delete();
        pop_log.delete();
        i_rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc, output int r);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        r             = cyc;
        step(1);
        i_redirect = 1'b0;
    endtask

    int     rel;
    int     r;
    int     k;
    ev_t    e;
    fetch_entry_t fe;

    initial begin
        #1;
        // Reset values and first fetch stream
        lat          = 1;
        i_req_ready  = 1'b1;
        i_inst_ready = 1'b1;
        i_rst        = 1'b1;
        step(2);
        check("rst_req_valid", 32'(o_req_valid), 32'd0);
        check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_inst_pc", o_inst_pc, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("rst_fault", 32'(o_fault), 32'd0);
`endif
        req_log.delete();
        pop_log.delete();
        i_rst = 1'b0;
        rel   = cyc;
        step(10);
        check("t1_first_req_cyc", 32'(req_at(0).cyc - rel), 32'd1);
        check("t1_req0", req_at(0).addr, 32'h100);
        check("t1_req1", req_at(1).addr, 32'h104);
        check("t1_req2", req_at(2).addr, 32'h108);
        check("t1_req_consec", 32'(req_at(2).cyc - req_at(0).cyc), 32'd2);
        check("t1_lat", 32'(pop_at(0).cyc - req_at(0).cyc), 32'd2);
        check("t1_pop0_pc", pop_at(0).addr, 32'h100);
        check("t1_pop0_inst", pop_at(0).inst, 32'hA5A5A4A5);
        check("t1_throughput", 32'(pop_at(4).cyc - pop_at(0).cyc), 32'd4);
        check("t1_pop4_pc", pop_at(4).addr, 32'h110);

        // Consumer stalled: credit limit of four
        i_inst_ready = 1'b0;
        do_reset();
        step(12);
        check("t2_nreq", 32'(req_log.size()), 32'd4);
        check("t2_req_valid", 32'(o_req_valid), 32'd0);
        check("t2_inst_valid", 32'(o_inst_valid), 32'd1);
        check("t2_head_pc", o_inst_pc, 32'h100);
        fe = dut.u_data_fifo.q[3];
        check("t2_peek_q3_pc", fe.pc, 32'h10C);
        req_log.delete();
        pop_log.delete();
        i_inst_ready = 1'b1;
        step(8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_pop%0d_pc", i), pop_at(i).addr,
                  32'h100 + 32'(4 * i));
        end
        check("t2_resume", req_at(0).addr, 32'h110);

        // Latency 3, two outstanding, redirect
        lat          = 3;
        i_req_ready  = 1'b0;
        i_inst_ready = 1'b1;
        do_reset();
        step(3);
        i_req_ready = 1'b1;
        step(2);
        i_req_ready = 1'b0;
        redirect(32'h200, r);
        i_req_ready = 1'b1;
        step(14);
        check("t3_npre", 32'(first_req_after(r - 1)), 32'd2);
        k = first_req_after(r);
        check("t3_new_addr", req_at(k).addr, 32'h200);
        check("t3_new_cyc", 32'(req_at(k).cyc - r), 32'd3);
        check("t3_pop_pc", pop_at(0).addr, 32'h200);
        check("t3_pop_inst", pop_at(0).inst, 32'hA5A5A7A5);

        // Redirect with handshake and response in the same cycle
        lat = 1;
        do_reset();
        step(6);
        redirect(32'h200, r);
        check("t4_valid_after", 32'(o_inst_valid), 32'd0);
        check("t4_reqv_after", 32'(o_req_valid), 32'd0);
        step(8);
        k = first_req_after(r - 1);
        check("t4_hs_in_redir", 32'(req_at(k).cyc - r), 32'd0);
        k = first_req_after(r);
        check("t4_new_addr", req_at(k).addr, 32'h200);
        check("t4_new_cyc", 32'(req_at(k).cyc - r), 32'd2);
        k = first_pop_after(r);
        check("t4_pop_pc", pop_at(k).addr, 32'h200);

        // PC wrap
        redirect(32'hFFFFFFFC, r);
        step(8);
        k = first_req_after(r);
        check("t5_req_a", req_at(k).addr, 32'hFFFFFFFC);
        check("t5_req_b", req_at(k + 1).addr, 32'h0);
        k = first_pop_after(r);
        check("t5_pop_a_pc", pop_at(k).addr, 32'hFFFFFFFC);
        check("t5_pop_a_inst", pop_at(k).inst, 32'h5A5A5A59);
        check("t5_pop_b_pc", pop_at(k + 1).addr, 32'h0);
        check("t5_pop_b_inst", pop_at(k + 1).inst, 32'hA5A5A5A5);

        // Misaligned redirect with a full FIFO
        i_inst_ready = 1'b0;
        do_reset();
        step(12);
        redirect(32'h202, r);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("t6_fault", 32'(o_fault), 32'd1);
        check("t6_req_valid", 32'(o_req_valid), 32'd0);
        check("t6_inst_valid", 32'(o_inst_valid), 32'd1);
        check("t6_head_pc", o_inst_pc, 32'h100);
        fe = dut.u_data_fifo.q[3];
        check("t6_peek_q3_pc", fe.pc, 32'h10C);
`else
        check("t6_flushed", 32'(o_inst_valid), 32'd0);
        i_inst_ready = 1'b1;
        step(6);
        k = first_req_after(r);
        check("t6_new_addr", req_at(k).addr, 32'h200);
        check("t6_new_cyc", 32'(req_at(k).cyc - r), 32'd1);
        k = first_pop_after(r);
        check("t6_pop_pc", pop_at(k).addr, 32'h200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
